ib_lut_addr_sched: RTL and testbench

//  Registered, parametrised successor of the CN/VN LUT address mappers. Takes a batch of PORT_NUM

---
 rtl/ib_lut_addr_sched.sv | 109 ++++++++++
 tb/tb_ib_lut_addr_sched.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ib_lut_addr_sched.sv
// Bank-interleaved IB-LUT address scheduler: maps (frame, y0, y1) per port to {page, bank}
// and replays ports so that no bank sees more than BANK_PORTS accesses in one cycle.
module ib_lut_addr_sched #(
  parameter int unsigned PORT_NUM        = 4,
  parameter int unsigned Y0_BW           = 2,
  parameter int unsigned Y1_BW           = 3,
  parameter int unsigned BANK_BW         = 1,
  parameter int unsigned BANK_PORTS      = 2,
  parameter int unsigned MULTI_FRAME_NUM = 2,
  parameter int unsigned CNT_BW          = 16,
  localparam int unsigned FRAME_BW       = $clog2(MULTI_FRAME_NUM),
  localparam int unsigned PAGE_BW        = FRAME_BW + Y0_BW + Y1_BW - BANK_BW
) (
  input  logic                          sys_clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [PORT_NUM-1:0]           port_en,
  input  logic [FRAME_BW-1:0]           frame_id,
  input  logic [PORT_NUM*Y0_BW-1:0]     y0_in,
  input  logic [PORT_NUM*Y1_BW-1:0]     y1_in,
  output logic [PORT_NUM-1:0]           out_valid,
  output logic [PORT_NUM*PAGE_BW-1:0]   page_addr,
  output logic [PORT_NUM*BANK_BW-1:0]   bank_addr,
  output logic [CNT_BW-1:0]             conflict_cnt
);

  localparam int unsigned USE_BW = $clog2(PORT_NUM + 1);
  localparam int unsigned HI_BW  = Y1_BW - BANK_BW;

  logic [PORT_NUM-1:0]         pending;
  logic [PORT_NUM-1:0]         grant;
  logic [PORT_NUM-1:0]         leftover;
  logic                        accept;
  logic [FRAME_BW-1:0]         frame_q;
  logic [PORT_NUM*Y0_BW-1:0]   y0_q;
  logic [PORT_NUM*Y1_BW-1:0]   y1_q;
  logic [PORT_NUM*PAGE_BW-1:0] page_map;
  logic [PORT_NUM*BANK_BW-1:0] bank_map;
  logic [BANK_BW-1:0]          bank_sel [PORT_NUM];

  // Address mapping from the latched batch
  for (genvar p = 0; p < PORT_NUM; p++) begin : g_map
    assign bank_sel[p] = y1_q[p*Y1_BW +: BANK_BW];
    assign bank_map[p*BANK_BW +: BANK_BW] = y1_q[p*Y1_BW +: BANK_BW];
    assign page_map[p*PAGE_BW +: PAGE_BW] =
      {frame_q, y0_q[p*Y0_BW +: Y0_BW], y1_q[p*Y1_BW + BANK_BW +: HI_BW]};
  end

  // Ascending-priority grant: a port wins if its bank still has a free access slot
  always_comb begin : grant_calc
    logic [USE_BW-1:0] used;
    grant = '0;
    used  = '0;
    for (int unsigned p = 0; p < PORT_NUM; p++) begin
      used = '0;
      for (int unsigned q = 0; q < PORT_NUM; q++) begin
        if ((q < p) && grant[q] && (bank_sel[q] == bank_sel[p])) begin
          used = used + USE_BW'(1);
        end
      end
      grant[p] = pending[p] && (used < USE_BW'(BANK_PORTS));
    end
  end

  assign leftover = pending & ~grant;
  assign in_ready = ~|leftover;
  assign accept   = in_valid & in_ready;

  // Batch registers and outstanding-port mask
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      frame_q <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
    end else if (accept) begin
      pending <= port_en;
      frame_q <= frame_id;
      y0_q    <= y0_in;
      y1_q    <= y1_in;
    end else begin
      pending <= leftover;
    end
  end

  // Registered RAM-side outputs; address lanes always follow the batch regs
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      out_valid <= '0;
      page_addr <= '0;
      bank_addr <= '0;
    end else begin
      out_valid <= grant;
      page_addr <= page_map;
      bank_addr <= bank_map;
    end
  end

  // Saturating stall counter
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if ((|leftover) && (conflict_cnt != '1)) begin
      conflict_cnt <= conflict_cnt + CNT_BW'(1);
    end
  end

endmodule

// File: tb/tb_ib_lut_addr_sched.sv
// Directed bench for ib_lut_addr_sched: default instance plus a 2-bit-counter instance
// sharing the same stimulus for the saturation case.
module tb_ib_lut_addr_sched;

  localparam logic [11:0] Y1_CONF = 12'b110_100_010_000;

  logic        sys_clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready, in_ready_s;
  logic [3:0]  port_en;
  logic [0:0]  frame_id;
  logic [7:0]  y0_in;
  logic [11:0] y1_in;
  logic [3:0]  out_valid, out_valid_s;
  logic [19:0] page_addr, page_addr_s;
  logic [3:0]  bank_addr, bank_addr_s;
  logic [15:0] conflict_cnt;
  logic [1:0]  conflict_cnt_s;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  ib_lut_addr_sched u_dut (
    .sys_clk(sys_clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .port_en(port_en), .frame_id(frame_id), .y0_in(y0_in), .y1_in(y1_in),
    .out_valid(out_valid), .page_addr(page_addr), .bank_addr(bank_addr),
    .conflict_cnt(conflict_cnt)
  );

  ib_lut_addr_sched #(.CNT_BW(2)) u_sat (
    .sys_clk(sys_clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .port_en(port_en), .frame_id(frame_id), .y0_in(y0_in), .y1_in(y1_in),
    .out_valid(out_valid_s), .page_addr(page_addr_s), .bank_addr(bank_addr_s),
    .conflict_cnt(conflict_cnt_s)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] en, input logic [0:0] fr,
                       input logic [7:0] y0, input logic [11:0] y1);
    in_valid = 1'b1;
    port_en  = en;
    frame_id = fr;
    y0_in    = y0;
    y1_in    = y1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] ii;
    logic [1:0] jj;
    rst = 1'b1; in_valid = 1'b0; port_en = '0; frame_id = '0; y0_in = '0; y1_in = '0;
    repeat (2) tick();
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_page", 32'(page_addr), 32'h0);
    check("rst_bank", 32'(bank_addr), 32'h0);
    check("rst_cnt", 32'(conflict_cnt), 32'h0);
    rst = 1'b0;
    tick();
    check("rst_ready", 32'(in_ready), 32'h1);

    // Single port, frame 1
    drive(4'b0001, 1'b1, 8'b00_00_00_10, 12'b000_000_000_101);
    #1 check("s1_ready", 32'(in_ready), 32'h1);
    tick(); idle();
    #1 check("s1_valid_c1", 32'(out_valid), 32'h0);
    tick();
    #1;
    check("s1_valid_c2", 32'(out_valid), 32'h1);
    check("s1_page0", 32'(page_addr[4:0]), 32'(5'b11010));
    check("s1_bank0", 32'(bank_addr[0]), 32'h1);
    check("s1_cnt", 32'(conflict_cnt), 32'h0);
    tick();
    #1 check("s1_valid_c3", 32'(out_valid), 32'h0);

    // Eight conflict-free batches back to back
    for (int i = 0; i < 10; i++) begin
      ii = 2'(i);
      jj = 2'(i - 2);
      if (i < 8) drive(4'hF, ii[0], {4{ii}}, {~ii, 1'b1, ~ii, 1'b0, ii, 1'b1, ii, 1'b0});
      else idle();
      #1;
      if (i < 8) check("s2_ready", 32'(in_ready), 32'h1);
      if (i >= 2) begin
        check("s2_valid", 32'(out_valid), 32'hF);
        check("s2_page0", 32'(page_addr[4:0]), 32'({jj[0], jj, jj}));
        check("s2_page3", 32'(page_addr[19:15]), 32'({jj[0], jj, ~jj}));
        check("s2_bank", 32'(bank_addr), 32'(4'b1010));
      end
      tick();
    end
    check("s2_valid_end", 32'(out_valid), 32'h0);
    check("s2_cnt", 32'(conflict_cnt), 32'h0);

    // All four ports on bank 0: two groups
    drive(4'hF, 1'b0, 8'h00, Y1_CONF);
    #1 check("s3_ready_c0", 32'(in_ready), 32'h1);
    tick(); idle();
    #1;
    check("s3_ready_c1", 32'(in_ready), 32'h0);
    check("s3_valid_c1", 32'(out_valid), 32'h0);
    tick();
    #1;
    check("s3_ready_c2", 32'(in_ready), 32'h1);
    check("s3_valid_c2", 32'(out_valid), 32'h3);
    check("s3_page1", 32'(page_addr[9:5]), 32'(5'b00001));
    check("s3_cnt_c2", 32'(conflict_cnt), 32'h1);
    tick();
    #1;
    check("s3_valid_c3", 32'(out_valid), 32'hC);
    check("s3_page3", 32'(page_addr[19:15]), 32'(5'b00011));
    check("s3_cnt_c3", 32'(conflict_cnt), 32'h1);
    tick();
    #1;
    check("s3_valid_c4", 32'(out_valid), 32'h0);
    check("s3_ready_c4", 32'(in_ready), 32'h1);

    // Empty port mask
    drive(4'h0, 1'b0, 8'h00, Y1_CONF);
    #1 check("s4_ready_c0", 32'(in_ready), 32'h1);
    tick(); idle();
    #1;
    check("s4_ready_c1", 32'(in_ready), 32'h1);
    check("s4_valid_c1", 32'(out_valid), 32'h0);
    tick();
    #1;
    check("s4_valid_c2", 32'(out_valid), 32'h0);
    check("s4_cnt", 32'(conflict_cnt), 32'h1);

    // Reset in the middle of a conflicting batch
    drive(4'hF, 1'b0, 8'h00, Y1_CONF);
    tick(); idle();
    tick();
    #1 check("s5_valid_c2", 32'(out_valid), 32'h3);
    rst = 1'b1;
    #1;
    check("s5_valid_rst", 32'(out_valid), 32'h0);
    check("s5_page_rst", 32'(page_addr), 32'h0);
    check("s5_cnt_rst", 32'(conflict_cnt), 32'h0);
    check("s5_cnt_s_rst", 32'(conflict_cnt_s), 32'h0);
    tick();
    rst = 1'b0;
    #1;
    check("s5_ready_rel", 32'(in_ready), 32'h1);
    check("s5_valid_rel", 32'(out_valid), 32'h0);
    tick();
    #1 check("s5_valid_n1", 32'(out_valid), 32'h0);
    tick();
    #1;
    check("s5_valid_n2", 32'(out_valid), 32'h0);
    check("s5_cnt_n2", 32'(conflict_cnt), 32'h0);

    // Saturation of the 2-bit counter
    for (int k = 0; k < 4; k++) begin
      check("s6_ready_s", 32'(in_ready_s), 32'h1);
      drive(4'hF, 1'b0, 8'h00, Y1_CONF);
      tick(); idle();
      tick();
      #1 check("s6_cnt_s", 32'(conflict_cnt_s), (k < 3) ? 32'(k + 1) : 32'h3);
      tick();
    end
    #1 check("s6_cnt_wide", 32'(conflict_cnt), 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
